// File: rtl/can_seq_pkg.sv
// Shared types and constants for the CAN frame sequencer.
// Optional watchdog is enabled by defining CAN_SEQ_TIMEOUT_EN.
package can_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_RELEASE = 3'd4
    } seqState_t;

    localparam int CRC_LEN     = 15;   // CRC field, still inside the stuffed region
    localparam int TAIL_LEN    = 10;   // CRC delim + ACK + ACK delim + EOF(7), never stuffed
    localparam int STUFF_RUN   = 5;    // equal samples that force a stuff bit
    localparam int WDOG_BITS   = 160;  // samples from SOF before giving up on a frame
    localparam int IDLE_PRESET = 7;    // EOF bits already seen recessive at frame end

    // Stuffed bits left after the header: data bytes (DLC capped at 8) plus CRC.
    function automatic logic [7:0] payloadBits(input logic [3:0] dlc);
        logic [7:0] bytes;
        bytes = (dlc > 4'd8) ? 8'd8 : {4'd0, dlc};
        return (bytes << 3) + 8'(CRC_LEN);
    endfunction

endpackage

// File: rtl/can_frame_sequencer_bit_timer.sv
// Bit-time prescaler: free-running down counter that strobes tick at 0 and
// reloads one bit period; load realigns the phase (used at the SOF edge).
module bit_timer #(
    parameter int CLKS_PER_BIT = 100,
    localparam int TW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] loadVal,
    output logic          tick
);

    logic [TW-1:0] count;

    // Tick is held off while reset is asserted so the strobe is quiet in reset.
    assign tick = !reset && (count == '0);

    // Down-count with reload; an explicit load always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count == '0) begin
            count <= TW'(CLKS_PER_BIT - 1);
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/can_frame_sequencer.sv
// CAN frame sequencer: waits for bus idle, follows one frame from SOF to EOF
// using the DLC from an external size detector, then resets that detector.
// Define CAN_SEQ_TIMEOUT_EN to add a per-frame watchdog driving errTimeout.
module can_frame_sequencer
    import can_seq_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int IDLE_BITS    = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       dIn,
    input  logic       completeConfig,
    input  logic [3:0] msgSize,
    output logic       detResetN,
    output logic       detEnable,
    output logic       samplePulse,
    output logic       frameActive,
    output logic       frameDone,
    output logic [3:0] frameDlc,
    output logic       errTimeout,
    output seqState_t  stateDbg
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(IDLE_BITS + IDLE_PRESET + 1);

    seqState_t     state, stateNext;
    logic [IW-1:0] idleCnt, idleNext;
    logic [2:0]    runCnt, runNext;
    logic          prevBit, prevNext;
    logic [7:0]    remaining, remNext;
    logic [3:0]    fixedCnt, fixedNext;
    logic          relCnt, relNext;
    logic [3:0]    dlcNext;
    logic          timerLoad;
    logic          sample;
    logic          inFrame;
`ifdef CAN_SEQ_TIMEOUT_EN
    logic [7:0]    wdogCnt, wdogNext;
    logic          suppressDone, suppressNext;
`endif

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) uTimer (
        .clk     (clk),
        .reset   (reset),
        .load    (timerLoad),
        .loadVal (TW'(CLKS_PER_BIT / 2)),
        .tick    (sample)
    );

    assign inFrame     = (state == S_HEADER) || (state == S_PAYLOAD);
    assign samplePulse = sample;
    assign frameActive = inFrame;
    assign detEnable   = (state == S_HEADER);
    assign detResetN   = !reset && (state != S_RELEASE);
    assign stateDbg    = state;
`ifndef CAN_SEQ_TIMEOUT_EN
    assign errTimeout  = 1'b0;
`endif

    // Next-state, counter updates and pulse outputs.
    always_comb begin
        stateNext = state;
        idleNext  = idleCnt;
        runNext   = runCnt;
        prevNext  = prevBit;
        remNext   = remaining;
        fixedNext = fixedCnt;
        relNext   = relCnt;
        dlcNext   = frameDlc;
        timerLoad = 1'b0;
        frameDone = 1'b0;
`ifdef CAN_SEQ_TIMEOUT_EN
        wdogNext     = wdogCnt;
        suppressNext = suppressDone;
        errTimeout   = 1'b0;
`endif
        // Run length of equal samples; the sample after a full run is the
        // stuff bit and always starts a fresh run.
        if (sample && inFrame) begin
            if (runCnt == 3'(STUFF_RUN) || runCnt == 3'd0 || dIn != prevBit) begin
                runNext = 3'd1;
            end else begin
                runNext = runCnt + 3'd1;
            end
            prevNext = dIn;
        end

        unique case (state)
            S_IDLE: begin
                if (sample) begin
                    if (!dIn) begin
                        idleNext = '0;
                    end else if (idleCnt < IW'(IDLE_BITS)) begin
                        idleNext = idleCnt + 1'b1;
                    end
                end
                if (enable && idleCnt >= IW'(IDLE_BITS)) begin
                    stateNext = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!enable) begin
                    stateNext = S_IDLE;
                end else if (!dIn) begin
                    stateNext = S_HEADER;
                    timerLoad = 1'b1;
                    runNext   = 3'd0;
`ifdef CAN_SEQ_TIMEOUT_EN
                    wdogNext     = 8'd0;
                    suppressNext = 1'b0;
`endif
                end
            end
            S_HEADER: begin
                // A sample in this same cycle is still a header bit.
                if (completeConfig) begin
                    dlcNext   = msgSize;
                    remNext   = payloadBits(msgSize);
                    stateNext = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (sample) begin
                    if (remaining != 8'd0) begin
                        if (runCnt != 3'(STUFF_RUN)) begin
                            remNext = remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                fixedNext = 4'(TAIL_LEN);
                            end
                        end
                    end else begin
                        if (fixedCnt != 4'd0) begin
                            fixedNext = fixedCnt - 4'd1;
                        end
                        if (fixedCnt <= 4'd1) begin
                            stateNext = S_RELEASE;
                            relNext   = 1'b0;
                        end
                    end
                end
            end
            S_RELEASE: begin
`ifdef CAN_SEQ_TIMEOUT_EN
                frameDone = !relCnt && !suppressDone;
`else
                frameDone = !relCnt;
`endif
                if (relCnt) begin
                    stateNext = S_IDLE;
                    idleNext  = IW'(IDLE_PRESET);
                    relNext   = 1'b0;
                end else begin
                    relNext = 1'b1;
                end
            end
            default: stateNext = S_IDLE;
        endcase

`ifdef CAN_SEQ_TIMEOUT_EN
        // Watchdog overrides normal progress once a frame overstays.
        if (sample && inFrame) begin
            if (wdogCnt == 8'(WDOG_BITS - 1)) begin
                errTimeout   = 1'b1;
                stateNext    = S_RELEASE;
                relNext      = 1'b0;
                suppressNext = 1'b1;
            end else begin
                wdogNext = wdogCnt + 8'd1;
            end
        end
`endif
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idleCnt   <= '0;
            runCnt    <= 3'd0;
            prevBit   <= 1'b0;
            remaining <= 8'd0;
            fixedCnt  <= 4'd0;
            relCnt    <= 1'b0;
            frameDlc  <= 4'd0;
`ifdef CAN_SEQ_TIMEOUT_EN
            wdogCnt      <= 8'd0;
            suppressDone <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            idleCnt   <= idleNext;
            runCnt    <= runNext;
            prevBit   <= prevNext;
            remaining <= remNext;
            fixedCnt  <= fixedNext;
            relCnt    <= relNext;
            frameDlc  <= dlcNext;
`ifdef CAN_SEQ_TIMEOUT_EN
            wdogCnt      <= wdogNext;
            suppressDone <= suppressNext;
`endif
        end
    end

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed bench for can_frame_sequencer (default parameters).
// Build with CAN_SEQ_TIMEOUT_EN defined to exercise the watchdog.
module tb_can_frame_sequencer;
    import can_seq_pkg::*;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       dIn;
    logic       completeConfig;
    logic [3:0] msgSize;
    logic       detResetN;
    logic       detEnable;
    logic       samplePulse;
    logic       frameActive;
    logic       frameDone;
    logic [3:0] frameDlc;
    logic       errTimeout;
    seqState_t  stateDbg;

    int compared   = 0;
    int mismatched = 0;
    int doneCnt    = 0;
    int errCnt     = 0;

    can_frame_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .dIn            (dIn),
        .completeConfig (completeConfig),
        .msgSize        (msgSize),
        .detResetN      (detResetN),
        .detEnable      (detEnable),
        .samplePulse    (samplePulse),
        .frameActive    (frameActive),
        .frameDone      (frameDone),
        .frameDlc       (frameDlc),
        .errTimeout     (errTimeout),
        .stateDbg       (stateDbg)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frameDone) doneCnt++;
        if (errTimeout) errCnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Step until samplePulse is seen; n is the number of edges taken.
    task automatic waitSample(input string tag, output int n);
        n = 0;
        do begin
            stepCycle();
            n++;
        end while (!samplePulse && n < 300);
        if (!samplePulse) check({tag, "_expired"}, 32'(samplePulse), 32'd1);
    endtask

    function automatic logic bitVal(input bit stuffed, input int j);
        if (stuffed && j <= 5) return 1'b0;
        if (stuffed && j == 6) return 1'b1;
        return (j % 2 == 0);
    endfunction

    // SOF, nine alternating header bits, completeConfig on the last header sample.
    task automatic startFrame(input logic [3:0] dlc, input bit checkTiming);
        int n;
        dIn = 1'b0;
        waitSample("sof_sample", n);
        if (checkTiming) check("first_sample_latency", 32'(n), 32'd51);
        stepCycle();
        for (int i = 0; i < 9; i++) begin
            dIn = (i % 2 == 0);
            waitSample("hdr_sample", n);
            if (checkTiming && i == 0) check("second_sample_period", 32'(n + 1), 32'd100);
            if (i < 8) stepCycle();
        end
        check("hdr_detEnable", 32'(detEnable), 32'd1);
        check("hdr_frameActive", 32'(frameActive), 32'd1);
        completeConfig = 1'b1;
        msgSize = dlc;
        stepCycle();
        completeConfig = 1'b0;
        check("latched_dlc", 32'(frameDlc), 32'(dlc));
        check("payload_state", 32'(stateDbg), 32'(S_PAYLOAD));
        check("payload_detEnable", 32'(detEnable), 32'd0);
    endtask

    // Drive payload/tail bits until frameDone; compare sample count to exp.
    task automatic finishFrame(input bit stuffed, input int exp, input string tag);
        int  j = 1;
        int  cnt = 0;
        bit  pending = 0;
        bit  done = 0;
        dIn = bitVal(stuffed, j);
        for (int k = 0; k < 15000 && !done; k++) begin
            stepCycle();
            if (frameDone) begin
                done = 1;
            end else begin
                if (pending) begin
                    dIn = bitVal(stuffed, j);
                    pending = 0;
                end
                if (samplePulse) begin
                    cnt++;
                    j++;
                    pending = 1;
                end
            end
        end
        dIn = 1'b1;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_samples_to_done"}, 32'(cnt), 32'(exp));
        check({tag, "_rel_detResetN0"}, 32'(detResetN), 32'd0);
        check({tag, "_rel_frameActive"}, 32'(frameActive), 32'd0);
        stepCycle();
        check({tag, "_rel_detResetN1"}, 32'(detResetN), 32'd0);
        check({tag, "_done_one_cycle"}, 32'(frameDone), 32'd0);
        stepCycle();
        check({tag, "_post_detResetN"}, 32'(detResetN), 32'd1);
        check({tag, "_post_idle"}, 32'(stateDbg), 32'(S_IDLE));
    endtask

    // Idle count resumes at 7: four recessive samples re-arm, three do not.
    task automatic rearmCheck(input string tag);
        repeat (250) stepCycle();
        check({tag, "_still_idle"}, 32'(stateDbg), 32'(S_IDLE));
        repeat (250) stepCycle();
        check({tag, "_rearmed"}, 32'(stateDbg), 32'(S_ARMED));
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        dIn = 1'b1;
        completeConfig = 1'b0;
        msgSize = 4'd0;
        repeat (3) stepCycle();
        check("rst_detResetN", 32'(detResetN), 32'd0);
        check("rst_detEnable", 32'(detEnable), 32'd0);
        check("rst_samplePulse", 32'(samplePulse), 32'd0);
        check("rst_frameActive", 32'(frameActive), 32'd0);
        check("rst_frameDone", 32'(frameDone), 32'd0);
        check("rst_frameDlc", 32'(frameDlc), 32'd0);
        check("rst_errTimeout", 32'(errTimeout), 32'd0);
        check("rst_state", 32'(stateDbg), 32'(S_IDLE));
        reset = 1'b0;
        enable = 1'b1;
        repeat (1200) stepCycle();
        check("init_armed", 32'(stateDbg), 32'(S_ARMED));

        // DLC 2, no stuffing: 16 data + 15 CRC + 10 tail samples.
        startFrame(4'd2, 1'b1);
        finishFrame(1'b0, 41, "dlc2");
        rearmCheck("after_dlc2");

        // DLC 2 with 00000 then a stuff bit: one extra sample.
        startFrame(4'd2, 1'b0);
        finishFrame(1'b1, 42, "dlc2_stuffed");
        rearmCheck("after_stuffed");

        // DLC 15 caps at 8 bytes: 64 + 15 + 10 samples.
        startFrame(4'd15, 1'b0);
        finishFrame(1'b0, 89, "dlc15");
        check("dlc15_held", 32'(frameDlc), 32'd15);
        check("done_count", 32'(doneCnt), 32'd3);
        rearmCheck("after_dlc15");

        // Reset in the middle of the payload.
        startFrame(4'd5, 1'b0);
        repeat (300) stepCycle();
        check("mid_payload", 32'(stateDbg), 32'(S_PAYLOAD));
        reset = 1'b1;
        stepCycle();
        check("midrst_state", 32'(stateDbg), 32'(S_IDLE));
        check("midrst_detResetN", 32'(detResetN), 32'd0);
        check("midrst_detEnable", 32'(detEnable), 32'd0);
        check("midrst_samplePulse", 32'(samplePulse), 32'd0);
        check("midrst_frameActive", 32'(frameActive), 32'd0);
        check("midrst_frameDone", 32'(frameDone), 32'd0);
        check("midrst_frameDlc", 32'(frameDlc), 32'd0);
        check("midrst_errTimeout", 32'(errTimeout), 32'd0);
        reset = 1'b0;
        dIn = 1'b1;
        repeat (900) stepCycle();
        check("midrst_not_armed_early", 32'(stateDbg), 32'(S_IDLE));
        repeat (200) stepCycle();
        check("midrst_rearmed", 32'(stateDbg), 32'(S_ARMED));
        check("midrst_no_done", 32'(doneCnt), 32'd3);

`ifdef CAN_SEQ_TIMEOUT_EN
        begin
            int  cnt = 0;
            bit  pending = 0;
            bit  seen = 0;
            dIn = 1'b0;
            for (int k = 0; k < 17000 && !seen; k++) begin
                stepCycle();
                if (pending) begin
                    dIn = ~dIn;
                    pending = 0;
                end
                if (samplePulse) begin
                    cnt++;
                    pending = 1;
                end
                if (errTimeout) seen = 1;
            end
            dIn = 1'b1;
            check("wdog_seen", 32'(seen), 32'd1);
            check("wdog_sample_index", 32'(cnt), 32'd160);
            stepCycle();
            check("wdog_release", 32'(stateDbg), 32'(S_RELEASE));
            check("wdog_detResetN0", 32'(detResetN), 32'd0);
            check("wdog_no_done", 32'(frameDone), 32'd0);
            stepCycle();
            check("wdog_detResetN1", 32'(detResetN), 32'd0);
            stepCycle();
            check("wdog_detResetN_back", 32'(detResetN), 32'd1);
            check("wdog_done_count", 32'(doneCnt), 32'd3);
            check("wdog_err_count", 32'(errCnt), 32'd1);
        end
`else
        check("no_timeout_pulses", 32'(errCnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
